// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the skid-buffered pipeline stage.
//   state_t     : occupancy of the stage (EMPTY, ONE = main only, FULL = main + skid)
//   STALL_CNT_W : width of the saturating stall counter
//   sat_inc     : saturating increment helper for the stall counter
package pipe_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == {STALL_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/flopr.sv
// flopr -- enabled register with synchronous active-high reset to zero.
//   clk   : clock
//   reset : synchronous clear (wins over en)
//   en    : load enable
//   d / q : WIDTH-bit data in / registered data out
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- one pipeline stage with a two-entry (main + skid) buffer so
// in_ready depends only on registered state, never combinationally on out_ready.
//   clk, reset          : clock, synchronous active-high reset
//   flush               : kill all held entries (and any same-cycle input beat)
//   in_valid/in_ready   : upstream handshake; in_data/in_ctrl upstream payload
//   out_valid/out_ready : downstream handshake; out_data/out_ctrl from main entry
//   stall_cycles        : saturating count of cycles with out_valid & ~out_ready
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W              = 16,
  parameter int CTRL_W              = 8,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int EW = DATA_W + CTRL_W;
  localparam int NENT = 2;  // entry 0 = main, entry 1 = skid

  state_t                      r_state, w_nxt;
  logic [STALL_CNT_W-1:0]      r_stall;
  logic [NENT-1:0][EW-1:0]     w_d, w_q;
  logic [NENT-1:0]             w_en;
  logic                        w_clr, w_acc, w_rel;

  assign in_ready  = (r_state != FULL) & ~reset;
  assign out_valid = (r_state != EMPTY);
  assign w_acc     = in_valid & in_ready;
  assign w_rel     = out_valid & out_ready;
  // Entry storage is cleared by reset, and also by flush when the stage is
  // configured to scrub stale payloads.
  assign w_clr     = reset | (CLEAR_DATA_ON_FLUSH & flush);

  always_comb begin
    w_nxt   = r_state;
    w_en    = '0;
    w_d[0]  = {in_data, in_ctrl};
    w_d[1]  = {in_data, in_ctrl};
    unique case (r_state)
      EMPTY: if (w_acc) begin
        w_nxt   = ONE;
        w_en[0] = 1'b1;
      end
      ONE: begin
        if (w_acc && w_rel) begin
          w_en[0] = 1'b1;
        end else if (w_rel) begin
          w_nxt = EMPTY;
        end else if (w_acc) begin
          w_nxt   = FULL;
          w_en[1] = 1'b1;
        end
      end
      FULL: if (w_rel) begin
        // in_ready is low here, so the only source for main is the skid entry
        w_nxt   = ONE;
        w_en[0] = 1'b1;
        w_d[0]  = w_q[1];
      end
      default: w_nxt = EMPTY;
    endcase
    if (flush) begin
      w_nxt = EMPTY;
      w_en  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_nxt;
  end

  for (genvar g = 0; g < NENT; g++) begin : g_ent
    flopr #(.WIDTH(EW)) u_ent (
      .clk   (clk),
      .reset (w_clr),
      .en    (w_en[g]),
      .d     (w_d[g]),
      .q     (w_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)                               r_stall <= '0;
    else if (out_valid & ~out_ready & ~flush) r_stall <= sat_inc(r_stall);
  end

  assign out_data     = w_q[0][EW-1:CTRL_W];
  // A bubble must never carry write enables downstream.
  assign out_ctrl     = out_valid ? w_q[0][CTRL_W-1:0] : '0;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_ready, out_valid, c_in_ready, c_out_valid;
  logic [15:0] out_data, c_out_data, stall_cycles, c_stall_cycles;
  logic [7:0]  out_ctrl, c_out_ctrl;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(8), .CLEAR_DATA_ON_FLUSH(1'b0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cycles(stall_cycles));

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(8), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
    .stall_cycles(c_stall_cycles));

  int n_chk = 0;
  int n_fail = 0;

  // reference model: FIFO of at most two beats plus a saturating stall count
  logic [15:0] mq_d[$];
  logic [7:0]  mq_c[$];
  int          m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic       ev;
    logic [7:0] ec;
    ev = (mq_d.size() > 0);
    ec = ev ? mq_c[0] : 8'h00;
    chk("in_ready",   {31'd0, in_ready},    {31'd0, ~reset & (mq_d.size() < 2)});
    chk("c_in_ready", {31'd0, c_in_ready},  {31'd0, ~reset & (mq_d.size() < 2)});
    chk("out_valid",  {31'd0, out_valid},   {31'd0, ev});
    chk("c_out_valid",{31'd0, c_out_valid}, {31'd0, ev});
    chk("out_ctrl",   {24'd0, out_ctrl},    {24'd0, ec});
    chk("c_out_ctrl", {24'd0, c_out_ctrl},  {24'd0, ec});
    if (ev) begin
      chk("out_data",   {16'd0, out_data},   {16'd0, mq_d[0]});
      chk("c_out_data", {16'd0, c_out_data}, {16'd0, mq_d[0]});
    end
    chk("stall",   {16'd0, stall_cycles},   m_stall);
    chk("c_stall", {16'd0, c_stall_cycles}, m_stall);
  endtask

  task automatic model_edge();
    int sz;
    bit acc, rel;
    if (reset) begin
      mq_d.delete(); mq_c.delete(); m_stall = 0;
    end else begin
      sz  = mq_d.size();
      acc = in_valid && (sz < 2);
      rel = (sz > 0) && out_ready;
      if (sz > 0 && !out_ready && !flush && m_stall < 65535) m_stall++;
      if (flush) begin
        mq_d.delete(); mq_c.delete();
      end else begin
        if (rel) begin void'(mq_d.pop_front()); void'(mq_c.pop_front()); end
        if (acc) begin mq_d.push_back(in_data); mq_c.push_back(in_ctrl); end
      end
    end
  endtask

  task automatic step(input bit do_chk);
    @(negedge clk);
    if (do_chk) check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input logic [7:0] c,
                       input bit ordy, input bit fl);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    @(posedge clk); model_edge(); #1;
    step(1);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_stall",    {16'd0, stall_cycles}, 32'd0);
    reset = 1'b0;
    #1 chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 8'(8'h10 + i), 1'b1, 1'b0);
      step(1);
    end
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    step(1); step(1);

    // fill to FULL, then drain in order
    drive(1'b1, 16'hAAAA, 8'h5A, 1'b0, 1'b0); step(1);
    drive(1'b1, 16'hBBBB, 8'hA5, 1'b0, 1'b0); step(1);
    drive(1'b1, 16'hDDDD, 8'hFF, 1'b0, 1'b0); step(1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0); step(1);
    chk("drain_first_b", {16'd0, out_data}, 32'hBBBB);
    step(1); step(1);

    // flush from FULL with a beat on the input
    drive(1'b1, 16'h1111, 8'h01, 1'b0, 1'b0); step(1);
    drive(1'b1, 16'h2222, 8'h02, 1'b0, 1'b0); step(1);
    drive(1'b1, 16'hCCCC, 8'hCC, 1'b1, 1'b1); step(1);
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_out_ctrl",  {24'd0, out_ctrl},  32'd0);
    for (int i = 0; i < 4; i++) step(1);

    // data retention vs clearing on flush
    drive(1'b1, 16'h1234, 8'h77, 1'b0, 1'b0); step(1);
    drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b1); step(1);
    flush = 1'b0;
    chk("hold_out_data",  {16'd0, out_data},   32'h1234);
    chk("clear_out_data", {16'd0, c_out_data}, 32'h0000);
    chk("hold_out_valid", {31'd0, out_valid},  32'd0);
    step(1);

    // stall counter saturation
    drive(1'b1, 16'h4242, 8'h42, 1'b0, 1'b0); step(1);
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) step(1'b0);
    step(1);
    chk("stall_sat",   {16'd0, stall_cycles}, 32'hFFFF);
    step(1);
    chk("stall_nowrap",{16'd0, stall_cycles}, 32'hFFFF);

    // reset in FULL overrides flush and handshakes
    drive(1'b1, 16'h9999, 8'h99, 1'b0, 1'b0); step(1);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #1 chk("rst_cycle_in_ready", {31'd0, in_ready}, 32'd0);
    step(1);
    chk("rst_full_valid", {31'd0, out_valid},   32'd0);
    chk("rst_full_data",  {16'd0, out_data},    32'd0);
    chk("rst_full_ctrl",  {24'd0, out_ctrl},    32'd0);
    chk("rst_full_stall", {16'd0, stall_cycles},32'd0);
    reset = 1'b0; flush = 1'b0;
    #1 chk("rst_full_rdy1", {31'd0, in_ready}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 4);
      reset     = ($urandom_range(0, 199) == 0);
      in_data   = 16'($urandom);
      in_ctrl   = 8'($urandom);
      step(1);
    end
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0); reset = 1'b0;
    step(1); step(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 16: payload width (ALU result, PC+1, operand fields).
REQ-002 Parameter CTRL_W, default 8: control-bit field width (write enables, halt, out_en, etc.).
REQ-003 Parameter CLEAR_DATA_ON_FLUSH, default 0: 1 = flush also zeroes held data.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous bubble insertion; kills all held entries.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_ready  out  1  stage accepts a beat this cycle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 out_valid  out  1  downstream beat present.
REQ-012 out_ready  in  1  downstream accepts a beat this cycle.
REQ-013 out_data  out  DATA_W  held payload.
REQ-014 out_ctrl  out  CTRL_W  held control bits; all zero whenever out_valid=0.
REQ-015 stall_cycles  out  16  saturating count of stalled output cycles.

Function
REQ-016 Two entries SHALL exist: main (drives outputs) and skid (overflow); order SHALL be preserved.
REQ-017 State SHALL be EMPTY (no entries), ONE (main only) or FULL (main+skid); skid is never valid without main.
REQ-018 Accept SHALL occur when in_valid & in_ready; release SHALL occur when out_valid & out_ready.
REQ-019 in_ready SHALL equal ~skid_valid & ~reset, driven from registered state only; no combinational path from out_ready.
REQ-020 EMPTY + accept -> ONE; the beat SHALL appear on out_* on the next cycle (latency 1).
REQ-021 ONE + accept + release -> ONE with new beat in main (throughput 1 beat/cycle).
REQ-022 ONE + release, no accept -> EMPTY.
REQ-023 ONE + accept, no release -> FULL; beat stored in skid.
REQ-024 FULL + release -> ONE; skid moves to main; no accept possible (in_ready=0).
REQ-025 FULL, no release -> FULL; all outputs held stable.
REQ-026 flush SHALL have priority over accept and release: next state EMPTY, any same-cycle input beat dropped, out_ctrl zero next cycle.
REQ-027 On flush, data registers SHALL hold their values unless CLEAR_DATA_ON_FLUSH=1, in which case they are zeroed.
REQ-028 A release coinciding with flush SHALL still be counted as taken by downstream (out_* valid that cycle).
REQ-029 stall_cycles SHALL increment each cycle with out_valid & ~out_ready & ~flush, saturating at 16'hFFFF; no wrap.
REQ-030 out_ctrl SHALL be gated by out_valid so that a bubble carries no write enables.

Reset
REQ-031 While reset=1 at a clock edge: state EMPTY, out_valid=0, out_data=0, out_ctrl=0, skid contents=0, stall_cycles=0.
REQ-032 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.
REQ-033 reset SHALL override flush and any handshake in the same cycle, including mid-FULL.

Structure
REQ-034 Package pipe_pkg SHALL hold the state enum (EMPTY, ONE, FULL) and constant STALL_CNT_W=16.
REQ-035 Entry storage SHALL reuse the existing flopr register (reset, enable, width parameter); no other sub-module.
REQ-036 Drop-in replacement of per-stage register blocks SHALL be possible with out_ready tied 1 and in_valid tied 1.

Verification
REQ-037 Stream 0x0001..0x0008 with out_ready=1 -> each appears 1 cycle later, in_ready constantly 1, stall_cycles=0.
REQ-038 Accept 0xAAAA, out_ready=0, accept 0xBBBB -> FULL, in_ready=0; out_ready=1 -> 0xAAAA then 0xBBBB out, in order.
REQ-039 FULL, flush=1 with in_valid=1 data 0xCCCC -> next cycle out_valid=0, out_ctrl=0, 0xCCCC never emitted.
REQ-040 out_valid=1, out_ready=0 for 70000 cycles -> stall_cycles saturates at 0xFFFF, no wrap.
REQ-041 Reset asserted in FULL -> next cycle all outputs zero, in_ready=0; cycle after: in_ready=1.
REQ-042 CLEAR_DATA_ON_FLUSH=1, hold 0x1234 then flush -> out_data=0x0000; with parameter 0 -> out_data stays 0x1234, out_valid=0.
